// File: rtl/plab5_mcore_dma_pkg.sv
// Shared encodings for the multicore DMA engine: FSM states and memory request types.
package plab5_mcore_dma_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE    = 3'd0,
    STATE_RD_REQ  = 3'd1,
    STATE_RD_WAIT = 3'd2,
    STATE_WR_REQ  = 3'd3,
    STATE_WR_WAIT = 3'd4,
    STATE_DONE    = 3'd5
  } dma_state_e;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

endpackage

// File: rtl/plab5_mcore_dma_engine.sv
// Word-by-word memory copy engine: one read then one write per word, at most
// one memory request outstanding, single-cycle ack when the copy finishes.
module plab5_mcore_dma_engine
  import plab5_mcore_dma_pkg::*;
#(
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32,
  parameter int p_len_nbits  = 8,
  parameter bit p_domain     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic [p_addr_nbits-1:0] req_src_addr,
  input  logic [p_addr_nbits-1:0] req_dest_addr,
  input  logic [p_len_nbits-1:0]  req_len,
  output logic                    req_domain,
  output logic                    ack,
  output logic                    busy,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic                    mem_req_type,
  output logic [p_addr_nbits-1:0] mem_req_addr,
  output logic [p_data_nbits-1:0] mem_req_data,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [p_data_nbits-1:0] mem_resp_data
);

  localparam logic [p_addr_nbits-1:0] WORD_BYTES = p_addr_nbits'(4);

  dma_state_e              state, state_next;
  logic [p_addr_nbits-1:0] src_reg, dest_reg;
  logic [p_len_nbits-1:0]  len_reg, count;
  logic [p_data_nbits-1:0] data_reg;

  logic accept, rd_done, wr_done, last_word;

  assign accept    = req_val & req_rdy;
  assign rd_done   = (state == STATE_RD_WAIT) & mem_resp_val;
  assign wr_done   = (state == STATE_WR_WAIT) & mem_resp_val;
  assign last_word = ((count + 1'b1) == len_reg);

  assign req_domain = p_domain;
  assign busy       = (state != STATE_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (accept)       count <= '0;
      else if (wr_done) count <= count + 1'b1;
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_reg  <= req_src_addr;
      dest_reg <= req_dest_addr;
      len_reg  <= req_len;
    end else if (wr_done) begin
      src_reg  <= src_reg + WORD_BYTES;
      dest_reg <= dest_reg + WORD_BYTES;
    end
    if (rd_done) data_reg <= mem_resp_data;
  end

  always_comb begin
    state_next   = state;
    req_rdy      = 1'b0;
    ack          = 1'b0;
    mem_req_val  = 1'b0;
    mem_req_type = MEM_REQ_READ;
    mem_req_addr = src_reg;
    mem_req_data = data_reg;
    mem_resp_rdy = 1'b0;
    unique case (state)
      STATE_IDLE: begin
        req_rdy      = 1'b1;
        // Responses arriving here are leftovers from an aborted transfer; drain them.
        mem_resp_rdy = 1'b1;
        if (req_val) state_next = (req_len == '0) ? STATE_DONE : STATE_RD_REQ;
      end
      STATE_RD_REQ: begin
        mem_req_val  = 1'b1;
        mem_req_type = MEM_REQ_READ;
        mem_req_addr = src_reg;
        if (mem_req_rdy) state_next = STATE_RD_WAIT;
      end
      STATE_RD_WAIT: begin
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) state_next = STATE_WR_REQ;
      end
      STATE_WR_REQ: begin
        mem_req_val  = 1'b1;
        mem_req_type = MEM_REQ_WRITE;
        mem_req_addr = dest_reg;
        mem_req_data = data_reg;
        if (mem_req_rdy) state_next = STATE_WR_WAIT;
      end
      STATE_WR_WAIT: begin
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) state_next = last_word ? STATE_DONE : STATE_RD_REQ;
      end
      STATE_DONE: begin
        ack        = 1'b1;
        state_next = STATE_IDLE;
      end
      default: state_next = STATE_IDLE;
    endcase
  end

endmodule

// File: doc/plab5_mcore_dma_engine.md
PLAB5_MCORE_DMA_ENGINE -- requirements
Module: plab5_mcore_dma_engine

Interface
REQ-001 SHALL have parameters: p_addr_nbits, default 32, address width; p_data_nbits, default 32, data width; p_len_nbits, default 8, word-count width; p_domain, default 0, security domain of this engine.
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock
  reset  in  1  reset; synchronous, active-high
  req_val  in  1  transfer request valid from the DMA checker
  req_rdy  out  1  engine can accept a request
  req_src_addr  in  p_addr_nbits  source byte address
  req_dest_addr  in  p_addr_nbits  destination byte address
  req_len  in  p_len_nbits  number of words to copy
  req_domain  out  1  constant p_domain, compared by the checker
  ack  out  1  one-cycle transfer-complete pulse
  busy  out  1  high in any state other than IDLE
  mem_req_val  out  1  memory request valid
  mem_req_rdy  in  1  memory accepts request
  mem_req_type  out  1  0 = read, 1 = write
  mem_req_addr  out  p_addr_nbits  memory byte address
  mem_req_data  out  p_data_nbits  write data
  mem_resp_val  in  1  memory response valid
  mem_resp_rdy  out  1  engine accepts response
  mem_resp_data  in  p_data_nbits  read data

Function
REQ-003 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-004 req_rdy SHALL be 1 only in IDLE; a request is accepted on a cycle where req_val & req_rdy.
REQ-005 On accept, the engine SHALL latch src, dest and len, clear the word counter, and go to DONE if len==0, otherwise to RD_REQ.
REQ-006 RD_REQ SHALL drive mem_req_val=1, type=0, addr=src_reg, and hold these until mem_req_rdy; then go to RD_WAIT.
REQ-007 RD_WAIT SHALL drive mem_resp_rdy=1; on mem_resp_val it SHALL latch mem_resp_data into data_reg and go to WR_REQ.
REQ-008 WR_REQ SHALL drive mem_req_val=1, type=1, addr=dest_reg, data=data_reg, and hold these until mem_req_rdy; then go to WR_WAIT.
REQ-009 WR_WAIT SHALL drive mem_resp_rdy=1; on mem_resp_val it SHALL add 4 to src_reg and dest_reg (wrap modulo 2^p_addr_nbits) and increment count; it SHALL go to DONE if count+1==len_reg, else to RD_REQ.
REQ-010 DONE SHALL assert ack=1 for exactly one cycle and then go to IDLE.
REQ-011 mem_req_val and mem_req_rdy SHALL be evaluated in the same cycle; the engine SHALL never keep more than one memory request outstanding.
REQ-012 In IDLE, mem_resp_rdy SHALL be 1 and stale responses SHALL be discarded without any state change.
REQ-013 Outputs not driven by the current state SHALL be 0 for valid, ready and ack signals, and don't-care for addr and data.
REQ-014 Minimum latency with zero-wait memory SHALL be 4 cycles per word plus 1 DONE cycle after the accept cycle.

Reset
REQ-015 Reset SHALL force state=IDLE and count=0, giving req_rdy=1, ack=0, busy=0, mem_req_val=0 and mem_resp_rdy=1.
REQ-016 Reset in the middle of a transfer SHALL abort the transfer without an ack pulse; any response that arrives later is drained per REQ-012.

Structure
REQ-017 The state encodings and the memory-type constants (read=0, write=1) SHALL live in a shared plab5_mcore_dma_pkg header.
REQ-018 The block SHALL be a single module with no sub-modules; the datapath registers (src, dest, len, count, data) SHALL be inline.

Verification
REQ-019 The bench SHALL cover: len=1, src=0x100, dest=0x200, zero-wait memory -> one read at 0x100, one write at 0x200 with the read data, and ack exactly 5 cycles after the accept cycle.
REQ-020 The bench SHALL cover: len=4, src=0x1000, dest=0x2000 -> reads at 0x1000, 0x1004, 0x1008, 0x100C, each followed by its write at 0x2000, 0x2004, 0x2008, 0x200C; exactly one ack.
REQ-021 The bench SHALL cover: len=0 -> no memory traffic, and ack on the cycle after the accept cycle.
REQ-022 The bench SHALL cover: mem_req_rdy held low for 3 cycles in RD_REQ -> mem_req_val/type/addr stay stable, and the transfer then completes correctly.
REQ-023 The bench SHALL cover: src=0xFFFFFFFC, len=2 -> the second read goes to 0x00000000.
REQ-024 The bench SHALL cover: reset asserted in WR_WAIT, then a late mem_resp_val -> no ack, req_rdy=1, and the late response is discarded.
